// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/PC-enable sequencing for the 3-stage core: memory waits, branch flush, debug halt/step, wait watchdog.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          mem_req_e,
  input  logic          mem_ack_i,
  input  logic          branch_taken_e,
  input  logic          halt_req_i,
  input  logic          step_req_i,
  output logic          stall_o,
  output logic          flush_o,
  output logic          pc_en_o,
  output logic          halted_o,
  output logic          timeout_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [DW-1:0] stall_cnt_o,
  output logic [DW-1:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, STEP} state_e;

  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q;
  logic          timeout_q;
  logic          step_q;
  logic          ret_halt_q;
  logic          step_rise;
  logic          wait_enter;
  logic          trip;
  logic          stall_raw;

  assign step_rise = step_req_i & ~step_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d    = state_q;
    wait_enter = 1'b0;
    trip       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req_e && !mem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_enter = 1'b1;
        end else if (halt_req_i) begin
          state_d = HALT;
        end
      end
      MEM_WAIT: begin
        // Halt requests wait here: an outstanding access is always completed.
        if (mem_ack_i) begin
          state_d = ret_halt_q ? HALT : RUN;
        end else if (wait_cnt_q == TIMEOUT_VAL) begin
          state_d = HALT;
          trip    = 1'b1;
        end
      end
      HALT: begin
        if (!timeout_q) begin
          if (step_rise)        state_d = STEP;
          else if (!halt_req_i) state_d = RUN;
        end
      end
      STEP: begin
        if (mem_req_e && !mem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_enter = 1'b1;
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      step_q     <= 1'b0;
      ret_halt_q <= 1'b0;
    end else begin
      step_q <= step_req_i;
      if (wait_enter)
        wait_cnt_q <= CW'(1);
      else if (state_q == MEM_WAIT && !mem_ack_i && !trip)
        wait_cnt_q <= wait_cnt_q + CW'(1);
      if (trip)
        timeout_q <= 1'b1;
      // A wait entered from a single step must return to HALT, not RUN.
      if (wait_enter && state_q == STEP)
        ret_halt_q <= 1'b1;
      else if (state_q == MEM_WAIT && state_d != MEM_WAIT)
        ret_halt_q <= 1'b0;
    end
  end

  always_comb begin
    stall_raw = 1'b0;
    unique case (state_q)
      RUN, STEP: stall_raw = mem_req_e & ~mem_ack_i;
      MEM_WAIT:  stall_raw = ~mem_ack_i;
      HALT:      stall_raw = 1'b1;
      default:   stall_raw = 1'b0;
    endcase
  end

  // Stall dominates flush so a pending branch flushes on the first unstalled cycle.
  assign stall_o   = rst_ni & stall_raw;
  assign flush_o   = rst_ni & branch_taken_e & ~stall_raw;
  assign pc_en_o   = ~stall_o;
  assign halted_o  = rst_ni & (state_q == HALT);
  assign timeout_o = timeout_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && state_q != HALT && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + DW'(1);
      if (flush_o && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + DW'(1);
    end
  end
`else
  // DW only sizes the counters; tie off a token use when they are absent.
  logic [DW-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a mode-flag reference model predicts each cycle's outputs.
// Build with PIPE_HAZARD_CTRL_PERF_EN defined to also check the event counters.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n, req, ack, br, halt, step;
  logic stall, flush, pc_en, halted, timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.DW(32), .TIMEOUT_CYCLES(TMO), .CW(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_req_e      (req),
    .mem_ack_i      (ack),
    .branch_taken_e (br),
    .halt_req_i     (halt),
    .step_req_i     (step),
    .stall_o        (stall),
    .flush_o        (flush),
    .pc_en_o        (pc_en),
    .halted_o       (halted),
    .timeout_o      (timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, pc_en, halted, timeout;
    logic [31:0] scnt, fcnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: plain mode flags derived from the behavioural rules.
  bit          m_halted, m_wait, m_step, m_back, m_trip, m_prev_step, last_stall;
  int          m_wcnt;
  int unsigned m_scnt, m_fcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_wait = 0; m_step = 0; m_back = 0; m_trip = 0;
    m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic drive(input bit r, input bit q_, input bit a, input bit b,
                       input bit h, input bit s);
    exp_t e;
    bit   st, rise;
    @(posedge clk); #1;
    rst_n = r; req = q_; ack = a; br = b; halt = h; step = s;
    e.timeout = m_trip;
    e.scnt    = m_scnt;
    e.fcnt    = m_fcnt;
    if (!r) begin
      e.stall = 0; e.flush = 0; e.pc_en = 1; e.halted = 0;
      model_reset();
    end else begin
      if (m_wait)        st = !a;
      else if (m_halted) st = 1;
      else               st = q_ && !a;
      e.stall  = st;
      e.flush  = b && !st;
      e.pc_en  = !st;
      e.halted = m_halted;
      if (st && !m_halted && m_scnt != 32'hffff_ffff) m_scnt++;
      if (e.flush && m_fcnt != 32'hffff_ffff)        m_fcnt++;
      rise = s && !m_prev_step;
      if (m_wait) begin
        if (a) begin
          m_wait = 0; m_halted = m_back; m_back = 0;
        end else if (m_wcnt == TMO) begin
          m_wait = 0; m_halted = 1; m_trip = 1; m_back = 0;
        end else begin
          m_wcnt++;
        end
      end else if (m_halted) begin
        if (!m_trip) begin
          if (rise)    begin m_halted = 0; m_step = 1; end
          else if (!h) m_halted = 0;
        end
      end else if (q_ && !a) begin
        m_wait = 1; m_wcnt = 1; m_back = m_step; m_step = 0;
      end else if (m_step) begin
        m_step = 0; m_halted = 1;
      end else if (h) begin
        m_halted = 1;
      end
    end
    m_prev_step = r ? s : 1'b0;
    last_stall  = e.stall;
    sb_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT shows on the falling edge against the oldest prediction.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("stall_o",   stall,   mon_e.stall);
        check("flush_o",   flush,   mon_e.flush);
        check("pc_en_o",   pc_en,   mon_e.pc_en);
        check("halted_o",  halted,  mon_e.halted);
        check("timeout_o", timeout, mon_e.timeout);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check("stall_cnt_o", stall_cnt, mon_e.scnt);
        check("flush_cnt_o", flush_cnt, mon_e.fcnt);
`endif
      end
    end
  end

  initial begin
    bit q_, b, h, s;
    rst_n = 0; req = 0; ack = 0; br = 0; halt = 0; step = 0;
    model_reset();
    m_prev_step = 0;
    last_stall  = 0;

    // Reset, then idle.
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);

    // Ack three cycles after the request.
    repeat (3) drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0);

    // Branch held through a two-cycle wait flushes only in the ack cycle.
    repeat (2) drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Halt, two single steps, release.
    repeat (3) drive(1, 0, 0, 0, 1, 0);
    repeat (2) begin
      drive(1, 0, 0, 0, 1, 1);
      repeat (3) drive(1, 0, 0, 0, 1, 0);
    end
    // Step that issues a waited access returns to HALT after the ack.
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 1, 0, 1, 0);
    repeat (2) drive(1, 0, 0, 0, 1, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);

    // Watchdog: ack never arrives; HALT is then terminal until reset.
    repeat (8) drive(1, 1, 0, 0, 0, 0);
    repeat (2) begin
      drive(1, 0, 0, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0);

    // Randomized traffic; request and branch stay stable while stalled.
    q_ = 0; b = 0; h = 0; s = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        q_ = ($urandom_range(0, 99) < 35);
        b  = ($urandom_range(0, 99) < 25);
      end
      if ($urandom_range(0, 99) < 8)  h = !h;
      if ($urandom_range(0, 99) < 25) s = !s;
      drive(($urandom_range(0, 99) >= 2), q_, ($urandom_range(0, 99) < 40), b, h, s);
    end

    @(negedge clk); #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
